lsu_bus_master: RTL and testbench

LSU_BUS_MASTER -- requirements
Module: lsu_bus_master

---
 rtl/lsu_bus_master_pkg.sv | 43 ++++
 rtl/lsu_bus_master_if.sv | 22 ++
 rtl/lsu_bus_master_load_data_aligner.sv | 37 +++
 rtl/lsu_bus_master.sv | 136 +++++++++++++
 tb/tb_lsu_bus_master.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/lsu_bus_master_pkg.sv
// Purpose: shared FSM state type, RV32I load/store funct3 codes and lane helpers for lsu_bus_master.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package lsu_bus_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_t;

    // Loads and stores share funct3 encodings for the byte/half/word sizes.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Place right-aligned store data on every lane it could land on; the byte
    // strobes pick the lane that actually gets written.
    function automatic logic [31:0] store_lanes(input logic [2:0] func3, input logic [31:0] wdata);
        logic [31:0] lanes;
        case (func3)
            F3_SB:   lanes = {4{wdata[7:0]}};
            F3_SH:   lanes = {2{wdata[15:0]}};
            default: lanes = wdata;
        endcase
        return lanes;
    endfunction

    // Halfword accesses must be 2-byte aligned, word accesses 4-byte aligned.
    function automatic logic misaligned(input logic [2:0] func3, input logic [1:0] addr_lo);
        logic half_acc;
        logic word_acc;
        half_acc = (func3 == F3_LH) || (func3 == F3_LHU);
        word_acc = (func3 == F3_LW);
        return (half_acc && addr_lo[0]) || (word_acc && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_bus_master_if.sv
// Purpose: word-wide single-outstanding request/ack bus between the LSU and memory.
// Latency: n/a (signal bundle only).
// Backpressure: master holds bus_req and payload stable until the slave returns bus_ack.
interface lsu_bus_master_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/lsu_bus_master_load_data_aligner.sv
// Purpose: pick the addressed byte/halfword out of a read word and sign/zero extend it.
// Latency: combinational.
// Backpressure: none.
module load_data_aligner
    import lsu_bus_master_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    output logic [31:0] rdata
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select followed by extension chosen by funct3; unknown funct3 reads as zero.
    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];

        rdata = 32'h0;
        case (func3)
            F3_LB:   rdata = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  rdata = {24'h0, byte_sel};
            F3_LH:   rdata = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  rdata = {16'h0, half_sel};
            F3_LW:   rdata = word;
            default: rdata = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu_bus_master.sv
// Purpose: turns one core load/store into one bus request, with timeout and optional misalign trap (LSU_MISALIGN_TRAP_EN).
// Latency: 2 cycles minimum (capture, request with same-cycle ack, done pulse); trapped accesses complete in 1.
// Backpressure: core is stalled until the done cycle; request is held until bus_ack or TIMEOUT wait cycles.
module lsu_bus_master
    import lsu_bus_master_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      core_valid,
    input  logic                      core_we,
    input  logic [2:0]                core_func3,
    input  logic [31:0]               core_addr,
    input  logic [31:0]               core_wdata,
    input  logic [3:0]                core_byteenable,
    output logic                      core_stall,
    output logic                      core_done,
    output logic [31:0]               core_rdata,
    output logic                      bus_err,
    lsu_bus_master_if.master          bus
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    lsu_state_t  state;
    logic [CW-1:0] wait_cnt;
    logic [CW-1:0] cnt_inc;
    logic        timeout_hit;
    logic        trap;

    logic        req_q;
    logic        we_q;
    logic [2:0]  func3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        done_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [31:0] ld_data;

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = misaligned(core_func3, core_addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    assign cnt_inc     = wait_cnt + 1'b1;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == CW'(TIMEOUT));

    load_data_aligner u_aligner (
        .func3   (func3_q),
        .addr_lo (addr_q[1:0]),
        .word    (bus.bus_rdata),
        .rdata   (ld_data)
    );

    // Stall is released in the done cycle so the core advances exactly once;
    // gated by reset so every output reads zero while reset is held.
    assign core_stall = rst_n & core_valid & (state != ST_DONE);
    assign core_done  = done_q;
    assign core_rdata = rdata_q;
    assign bus_err    = err_q;

    assign bus.bus_req   = req_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = {addr_q[31:2], 2'b00};
    assign bus.bus_wdata = wdata_q;
    assign bus.bus_be    = be_q;

    // Request FSM with registered bus payload and core completion outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            func3_q  <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            be_q     <= 4'h0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= 32'h0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (core_valid) begin
                        we_q    <= core_we;
                        func3_q <= core_func3;
                        addr_q  <= core_addr;
                        wdata_q <= store_lanes(core_func3, core_wdata);
                        be_q    <= core_we ? core_byteenable : 4'h0;
                        if (trap) begin
                            // Misaligned access never reaches the bus.
                            rdata_q <= 32'h0;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            state   <= ST_DONE;
                        end else begin
                            wait_cnt <= '0;
                            req_q    <= 1'b1;
                            state    <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (bus.bus_ack) begin
                        rdata_q <= ld_data;
                        req_q   <= 1'b0;
                        done_q  <= 1'b1;
                        state   <= ST_DONE;
                    end else if (timeout_hit) begin
                        rdata_q <= 32'h0;
                        req_q   <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        state   <= ST_DONE;
                    end else begin
                        wait_cnt <= cnt_inc;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bus_master.sv
// Purpose: directed plus random load/store transactions against a reference model of lane and extension rules.
// Latency: checks every cycle of each transaction (capture, request, done, idle).
// Backpressure: ack delay chosen per transaction, including delays beyond the timeout.
module tb_lsu_bus_master;
    import lsu_bus_master_pkg::*;

    localparam int TOUT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        core_valid = 1'b0;
    logic        core_we = 1'b0;
    logic [2:0]  core_func3 = 3'b000;
    logic [31:0] core_addr = 32'h0;
    logic [31:0] core_wdata = 32'h0;
    logic [3:0]  core_byteenable = 4'h0;
    logic        core_stall;
    logic        core_done;
    logic [31:0] core_rdata;
    logic        bus_err;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_rdata = 32'h0;

    lsu_bus_master_if bus ();

    lsu_bus_master #(.TIMEOUT(TOUT)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .core_valid      (core_valid),
        .core_we         (core_we),
        .core_func3      (core_func3),
        .core_addr       (core_addr),
        .core_wdata      (core_wdata),
        .core_byteenable (core_byteenable),
        .core_stall      (core_stall),
        .core_done       (core_done),
        .core_rdata      (core_rdata),
        .bus_err         (bus_err),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: shift the addressed element down, then extend by arithmetic.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] word);
        logic [31:0] bsh;
        logic [31:0] hsh;
        bsh = word >> (8 * addr[1:0]);
        hsh = word >> (addr[1] ? 16 : 0);
        case (f3)
            3'd0:    return 32'($signed(bsh[7:0]));
            3'd4:    return bsh & 32'h0000_00FF;
            3'd1:    return 32'($signed(hsh[15:0]));
            3'd5:    return hsh & 32'h0000_FFFF;
            3'd2:    return word;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] ref_store(input logic [2:0] f3, input logic [31:0] w);
        case (f3)
            3'd0:    return w[7:0] * 32'h0101_0101;
            3'd1:    return w[15:0] * 32'h0001_0001;
            default: return w;
        endcase
    endfunction

    function automatic bit ref_trap(input logic [2:0] f3, input logic [31:0] addr);
`ifdef LSU_MISALIGN_TRAP_EN
        return ((f3 == 3'd1 || f3 == 3'd5) && addr[0]) || (f3 == 3'd2 && addr[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    // Called at a falling edge with the DUT idle; returns at a falling edge with the DUT idle.
    // d = REQ cycle index (0-based) in which bus_ack is raised.
    task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input int d,
                          input logic [31:0] rd);
        bit trap;
        bit tmo;
        int nreq;
        logic [31:0] exp_rd;
        trap   = ref_trap(f3, addr);
        tmo    = !trap && (d >= TOUT);
        nreq   = tmo ? TOUT : d + 1;
        exp_rd = (trap || tmo) ? 32'h0 : ref_load(f3, addr, rd);

        core_valid = 1'b1; core_we = we; core_func3 = f3; core_addr = addr;
        core_wdata = wdata; core_byteenable = be;
        bus.bus_ack = 1'($urandom_range(0, 1));   // stray ack while idle must be ignored
        bus.bus_rdata = $urandom;
        #1;
        chk("stall_capture", core_stall, 1);
        chk("req_capture", bus.bus_req, 0);

        if (!trap) begin
            for (int i = 0; i < nreq; i++) begin
                @(negedge clk);
                chk("bus_req", bus.bus_req, 1);
                chk("bus_addr", bus.bus_addr, addr & 32'hFFFF_FFFC);
                chk("bus_we", bus.bus_we, we);
                chk("bus_be", bus.bus_be, we ? be : 4'h0);
                if (we) chk("bus_wdata", bus.bus_wdata, ref_store(f3, wdata));
                chk("stall_req", core_stall, 1);
                chk("done_req", core_done, 0);
                bus.bus_ack   = (i == d);
                bus.bus_rdata = (i == d) ? rd : $urandom;
            end
        end

        @(negedge clk);
        bus.bus_ack = 1'($urandom_range(0, 1));   // ack outside REQ must be ignored
        chk("done_pulse", core_done, 1);
        chk("err_pulse", bus_err, trap || tmo);
        chk("rdata_done", core_rdata, exp_rd);
        chk("stall_done", core_stall, 0);
        chk("req_done", bus.bus_req, 0);
        last_rdata = exp_rd;

        core_valid = 1'b0;
        @(negedge clk);
        bus.bus_ack = 1'b0;
        chk("done_single", core_done, 0);
        chk("err_single", bus_err, 0);
        chk("rdata_hold", core_rdata, last_rdata);
        chk("req_idle", bus.bus_req, 0);
    endtask

    initial begin
        bus.bus_ack = 1'b0;
        bus.bus_rdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_req", bus.bus_req, 0);
        chk("rst_done", core_done, 0);
        chk("rst_err", bus_err, 0);
        chk("rst_rdata", core_rdata, 32'h0);
        chk("rst_addr", bus.bus_addr, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Word store, ack in first request cycle.
        run_op(1'b1, F3_SW, 32'h100, 32'hDEAD_BEEF, 4'b1111, 0, $urandom);
        // Byte store to lane 3, ack in third request cycle.
        run_op(1'b1, F3_SB, 32'h103, 32'h0000_00A5, 4'b1000, 2, $urandom);
        // Byte/halfword loads from lane 2 of the same word.
        run_op(1'b0, F3_LB, 32'h102, 32'h0, 4'h0, 1, 32'h12F0_3456);
        chk("lb_const", core_rdata, 32'hFFFF_FFF0);
        run_op(1'b0, F3_LBU, 32'h102, 32'h0, 4'h0, 0, 32'h12F0_3456);
        chk("lbu_const", core_rdata, 32'h0000_00F0);
        run_op(1'b0, F3_LH, 32'h102, 32'h0, 4'h0, 3, 32'h12F0_3456);
        chk("lh_const", core_rdata, 32'h0000_12F0);
        // No ack at all: timeout after TOUT request cycles.
        run_op(1'b0, F3_LW, 32'h40, 32'h0, 4'h0, TOUT + 2, $urandom);
        chk("tmo_rdata", core_rdata, 32'h0);

        // Reset in the middle of a request.
        core_valid = 1'b1; core_we = 1'b0; core_func3 = F3_LW; core_addr = 32'h200;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_req", bus.bus_req, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_req", bus.bus_req, 0);
        chk("mid_rst_stall", core_stall, 0);
        chk("mid_rst_done", core_done, 0);
        chk("mid_rst_rdata", core_rdata, 32'h0);
        chk("mid_rst_addr", bus.bus_addr, 32'h0);
        last_rdata = 32'h0;
        core_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(1'b0, F3_LW, 32'h204, 32'h0, 4'h0, 1, 32'hCAFE_F00D);

        // Misaligned word load: trapped when the check is built in, normal otherwise.
        run_op(1'b0, F3_LW, 32'h101, 32'h0, 4'h0, 0, 32'h8765_4321);

        // Random mix of loads and stores with random ack delays.
        for (int n = 0; n < 40; n++) begin
            logic we_r;
            logic [2:0] f3_r;
            we_r = 1'($urandom_range(0, 1));
            f3_r = we_r ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            run_op(we_r, f3_r, $urandom, $urandom, 4'($urandom), $urandom_range(0, TOUT + 1), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
